pc_branch_ctrl: RTL and testbench

//  Program-counter and branch-control stage directly downstream of the ALU.
//  - Latches the ALU 1-bit flag output ('out') into a stored condition flag.
//  - Advances the program counter each cycle.
//  - Resolves unconditional jumps and flag-conditional branches through a

---
 rtl/pc_branch_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_branch_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// Purpose : program counter and branch control after the ALU; run/halt
//           sequencing, stored condition flag, writable jump-target table.
// Latency : start->busy, halt->done and jump/branch->prog_ctr are each 1 cycle.
// Backpressure: none; the program sequence is paced by start/halt only.
//
// Ports:
//   clk, reset              single rising-edge clock, async active-high reset
//   start                   level run request; must drop to leave DONE
//   halt, jump, branch      decoded control, honoured only in RUN
//   lut_idx                 target-table index for jump/branch
//   flag_we, alu_flag       capture ALU flag into flag_q (RUN only)
//   lut_we/waddr/wdata      synchronous target-table write, any state
//   prog_ctr, flag_q        registered PC and stored condition flag
//   busy, done              state == RUN / state == DONE
module pc_branch_ctrl #(
  parameter int              PC_W       = 10,
  parameter int              LUT_AW     = 4,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              jump,
  input  logic              branch,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              flag_we,
  input  logic              alu_flag,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   prog_ctr,
  output logic              flag_q,
  output logic              busy,
  output logic              done
);

  localparam int LUT_DEPTH = 1 << LUT_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_d;
  logic            flag_d;
  logic [PC_W-1:0] lut_mem [LUT_DEPTH];
  logic [PC_W-1:0] lut_rd;
  logic            take_target;

  // ---------------------------------------------------------------------------
  // Branch-target table. Read is combinational; since the write lands on the
  // clock edge, a same-cycle write to the index being read is not visible
  // until the following cycle, so the old entry is returned.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_mem[i] <= '0;
      end
    end else if (lut_we) begin
      lut_mem[lut_waddr] <= lut_wdata;
    end
  end

  assign lut_rd = lut_mem[lut_idx];

  // A conditional branch tests the flag as it stands at the start of the
  // cycle, so a flag_we in the same cycle cannot influence it.
  assign take_target = jump || (branch && flag_q);

  // ---------------------------------------------------------------------------
  // State, PC and flag registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prog_ctr <= START_ADDR;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prog_ctr <= pc_d;
      flag_q   <= flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, next-PC and next-flag. Control inputs are only decoded in RUN.
  // Next-PC priority in RUN: halt (hold) > jump > taken branch > pc+1.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = prog_ctr;
    flag_d  = flag_q;

    unique case (state_q)
      ST_IDLE: begin
        // PC parks at the start address so the first RUN cycle executes it.
        pc_d = START_ADDR;
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (halt) begin
          // Freeze on the halt instruction's address.
          state_d = ST_DONE;
        end else if (take_target) begin
          pc_d = lut_rd;
        end else begin
          // Natural wrap modulo 2**PC_W; no overflow indication.
          pc_d = prog_ctr + PC_W'(1);
        end

        if (flag_we) begin
          flag_d = alu_flag;
        end
      end

      ST_DONE: begin
        // Holding start keeps us here; a new run needs start to drop first.
        if (!start) begin
          state_d = ST_IDLE;
          pc_d    = START_ADDR;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
module tb_pc_branch_ctrl;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int PC_MOD = 1 << PC_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, halt, jump, branch, flag_we, alu_flag, lut_we;
  logic [LUT_AW-1:0] lut_idx, lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   prog_ctr;
  logic              flag_q, busy, done;

  int n_vec = 0;
  int n_err = 0;

  pc_branch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .START_ADDR('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt      (halt),
    .jump      (jump),
    .branch    (branch),
    .lut_idx   (lut_idx),
    .flag_we   (flag_we),
    .alu_flag  (alu_flag),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .prog_ctr  (prog_ctr),
    .flag_q    (flag_q),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       start, halt, jump, branch, flag_we, alu_flag;
    logic [3:0] idx;
    logic       lwe;
    logic [3:0] waddr;
    logic [9:0] wdata;
    logic [9:0] e_pc;
    logic       e_flag, e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic s, logic h, logic j, logic b,
                              logic fwe, logic af, int idx, logic lwe, int wa,
                              int wd, int epc, logic ef, logic eb, logic ed);
    vec_t v;
    v.name = name; v.start = s; v.halt = h; v.jump = j; v.branch = b;
    v.flag_we = fwe; v.alu_flag = af; v.idx = 4'(idx); v.lwe = lwe;
    v.waddr = 4'(wa); v.wdata = 10'(wd); v.e_pc = 10'(epc);
    v.e_flag = ef; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_outs(string name, int epc, int ef, int eb, int ed);
    check({name, ".pc"},   int'(prog_ctr), epc);
    check({name, ".flag"}, int'(flag_q),   ef);
    check({name, ".busy"}, int'(busy),     eb);
    check({name, ".done"}, int'(done),     ed);
  endtask

  task automatic drive(logic s, logic h, logic j, logic b, logic fwe, logic af,
                       int idx, logic lwe, int wa, int wd);
    start = s; halt = h; jump = j; branch = b; flag_we = fwe; alu_flag = af;
    lut_idx = LUT_AW'(idx); lut_we = lwe; lut_waddr = LUT_AW'(wa);
    lut_wdata = PC_W'(wd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: program run described by two booleans and integer PC.
  bit m_running, m_finished, m_flag;
  int m_pc;
  int m_lut[16];

  task automatic model_reset();
    m_running = 0; m_finished = 0; m_flag = 0; m_pc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic model_step();
    int target;
    target = m_lut[lut_idx];
    if (m_running) begin
      if (halt) begin
        m_running = 0; m_finished = 1;
      end else if (jump || (branch && m_flag)) begin
        m_pc = target;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
      if (flag_we) m_flag = alu_flag;
    end else if (m_finished) begin
      if (!start) begin
        m_finished = 0; m_pc = 0;
      end
    end else begin
      m_pc = 0;
      if (start) m_running = 1;
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: writes lut[3]=0x2A, lut[1]=5, lut[2]=9, lut[7]=0x3FE.
    //                  name              s h j b fw af idx lwe wa wd    pc  f b d
    vecs.push_back(mk("start_busy",      1,0,0,0,0,0, 0, 1,3,'h2A, 0,    0,1,0));
    vecs.push_back(mk("run_pc1",         1,0,0,0,0,0, 0, 1,1,5,    1,    0,1,0));
    vecs.push_back(mk("run_pc2",         1,0,0,0,0,0, 0, 1,2,9,    2,    0,1,0));
    vecs.push_back(mk("run_pc3",         1,0,0,0,0,0, 0, 1,7,'h3FE,3,    0,1,0));
    vecs.push_back(mk("flag_set",        1,0,0,0,1,1, 0, 0,0,0,    4,    1,1,0));
    vecs.push_back(mk("branch_taken",    1,0,0,1,0,0, 3, 0,0,0,    'h2A, 1,1,0));
    vecs.push_back(mk("jump_flag_clr",   1,0,1,0,1,0, 1, 0,0,0,    5,    0,1,0));
    vecs.push_back(mk("branch_not_tkn",  1,0,0,1,0,0, 3, 0,0,0,    6,    0,1,0));
    vecs.push_back(mk("jump_uncond",     1,0,1,0,0,0, 3, 0,0,0,    'h2A, 0,1,0));
    vecs.push_back(mk("branch_old_flag", 1,0,0,1,1,1, 3, 0,0,0,    'h2B, 1,1,0));
    vecs.push_back(mk("lut_same_cycle",  1,0,1,0,0,0, 4, 1,4,'h77, 0,    1,1,0));
    vecs.push_back(mk("lut_new_value",   1,0,1,0,0,0, 4, 0,0,0,    'h77, 1,1,0));
    vecs.push_back(mk("jump_to_9",       1,0,1,0,0,0, 2, 0,0,0,    9,    1,1,0));
    vecs.push_back(mk("halt_over_jump",  1,1,1,0,0,0, 3, 0,0,0,    9,    1,0,1));
    vecs.push_back(mk("done_hold",       1,0,1,0,1,0, 3, 0,0,0,    9,    1,0,1));
    vecs.push_back(mk("done_to_idle",    0,0,0,0,0,0, 0, 0,0,0,    0,    1,0,0));
    vecs.push_back(mk("idle_ignore1",    0,1,1,0,1,0, 3, 0,0,0,    0,    1,0,0));
    vecs.push_back(mk("idle_ignore2",    0,1,0,1,0,0, 3, 0,0,0,    0,    1,0,0));
    vecs.push_back(mk("restart",         1,0,0,0,0,0, 0, 0,0,0,    0,    1,1,0));
    vecs.push_back(mk("jump_1022",       1,0,1,0,0,0, 7, 0,0,0,    'h3FE,1,1,0));
    vecs.push_back(mk("pc_1023",         1,0,0,0,0,0, 0, 0,0,0,    'h3FF,1,1,0));
    vecs.push_back(mk("pc_wrap",         1,0,0,0,0,0, 0, 0,0,0,    0,    1,1,0));
    vecs.push_back(mk("pc_after_wrap",   1,0,0,0,0,0, 0, 0,0,0,    1,    1,1,0));

    #12;
    check_outs("reset", 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].jump, vecs[i].branch,
            vecs[i].flag_we, vecs[i].alu_flag, int'(vecs[i].idx), vecs[i].lwe,
            int'(vecs[i].waddr), int'(vecs[i].wdata));
      tick();
      check_outs(vecs[i].name, int'(vecs[i].e_pc), int'(vecs[i].e_flag),
                 int'(vecs[i].e_busy), int'(vecs[i].e_done));
    end

    // Mid-RUN asynchronous reset between edges: outputs clear with no edge.
    #2 reset = 1'b1;
    #1 check_outs("async_reset", 0, 0, 0, 0);
    #10 reset = 1'b0;

    // Table was cleared: jump via lut[3] now lands on 0, not 0x2A.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("post_reset_run", 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 0, 3, 0, 0, 0);
    tick();
    check_outs("lut_cleared", 0, 0, 1, 0);

    // Randomised run against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1015, 1023))
                                        : int'($urandom_range(0, 1023)));
      tick();
      model_step();
      check_outs("random", m_pc, int'(m_flag), int'(m_running),
                 int'(m_finished));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
